// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD display path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bcd_pkg;

  // Largest magnitude the three-digit display can show (hundreds digit 0..3).
  localparam int MAX_DISPLAY = 399;
  localparam int BCD_OUT_W   = 10;
  localparam int BCD_ACC_W   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dd_add3.sv
// Double-dabble nibble corrector: adds 3 when the BCD digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
module dd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // A digit of 5..9 becomes 8..12 so the following left shift carries into the next digit.
  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_value_converter.sv
// Iterative binary-to-BCD converter feeding the 7-segment driver; optional signed input via BCD_SIGNED_EN.
// Latency: DATA_W+1 cycles from accepting start to the done pulse; one conversion per DATA_W+2 cycles.
// Backpressure: start is taken only in IDLE; a start while busy is dropped, never queued.
module bcd_value_converter
  import bcd_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_OUT_W-1:0] BCD_digit,
  output logic                 sign,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    mag;
  logic [DATA_W-1:0]    mag_in;
  logic [BCD_ACC_W-1:0] bcd;
  logic [BCD_ACC_W-1:0] bcd_adj;
  logic                 ovf_r;
  logic                 ovf_in;
  logic                 busy_nxt;
  logic                 unused_bits;

`ifdef BCD_SIGNED_EN
  logic sign_in;
  logic sign_r;

  // Two's complement input: the magnitude of the most negative value still fits unsigned.
  assign sign_in = data_in[DATA_W-1];
  assign mag_in  = sign_in ? -data_in : data_in;
`else
  assign mag_in  = data_in;
`endif

  // Overflow is decided once on the binary magnitude, not from the BCD result.
  assign ovf_in = (BCD_ACC_W'(mag_in) > BCD_ACC_W'(MAX_DISPLAY));

  for (genvar g = 0; g < 3; g++) begin : g_add3
    dd_add3 u_add3 (
      .digit     (bcd[4*g +: 4]),
      .corrected (bcd_adj[4*g +: 4])
    );
  end

  // Top corrected bit is always shifted out; it only matters for overflowed values.
  assign unused_bits = bcd_adj[BCD_ACC_W-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; busy stays up through the cycle in which done is shown.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE) || (state == DONE);
  end

  // Capture on accept, then one correct-and-shift step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mag   <= mag_in;
            bcd   <= '0;
            cnt   <= CNT_W'(DATA_W);
            ovf_r <= ovf_in;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[BCD_ACC_W-2:0], mag[DATA_W-1]};
          mag <= {mag[DATA_W-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Display-facing registers change only when leaving DONE, so no partial result is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BCD_digit <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= (state == DONE);
      busy <= busy_nxt;
      if (state == DONE) begin
        BCD_digit <= ovf_r ? '0 : bcd[BCD_OUT_W-1:0];
        overflow  <= ovf_r;
      end
    end
  end

`ifdef BCD_SIGNED_EN
  // Sign is captured at accept and published with the digits; zero always yields a clear MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
      sign   <= 1'b0;
    end else begin
      if (state == IDLE && start) sign_r <= sign_in;
      if (state == DONE)          sign   <= sign_r;
    end
  end
`else
  assign sign = 1'b0;
`endif

endmodule

// File: doc/bcd_value_converter.md
# bcd_value_converter

Sequential binary-to-BCD converter, directly upstream of the 7-segment display driver on the Nexys7 board. Takes a signed binary result (the ALU/datapath value), performs iterative double-dabble conversion, and presents three BCD digits plus sign and overflow flags in the exact format the display driver consumes. Outputs are registered and held stable between conversions, so the display never shows intermediate values.

## Interface
- `DATA_W`, default 10: input width, legal range 4..10.
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a conversion of `data_in`; sampled only in IDLE.
- `data_in`  in  DATA_W  value to convert; two's complement when `BCD_SIGNED_EN` is defined, unsigned otherwise.
- `busy`  out  1  high while a conversion is in progress (SHIFT and DONE states).
- `done`  out  1  one-cycle pulse when the outputs update.
- `BCD_digit`  out  10  [3:0] ones, [7:4] tens, [9:8] hundreds (0..3).
- `sign`  out  1  1 = negative value.
- `overflow`  out  1  1 = magnitude > 399 (not displayable).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1: capture `sign_r` = MSB of `data_in` (signed mode).
  - Capture `mag` = |data_in| as DATA_W-bit unsigned; -512 → 512 fits.
  - Capture `ovf_r` = (mag > 399), a binary compare made at capture.
  - Clear the 12-bit BCD accumulator; load `cnt` = DATA_W; go to SHIFT.
- SHIFT, one bit per cycle:
  - Each BCD nibble ≥ 5 gets +3.
  - Then shift {bcd, mag} left by 1 and decrement `cnt`.
  - When `cnt` == 1 on this edge (last shift), go to DONE.
- DONE:
  - Register `BCD_digit` = ovf_r ? 0 : {bcd[9:8], bcd[7:4], bcd[3:0]}.
  - Register `sign` = sign_r and `overflow` = ovf_r.
  - Assert `done` for one cycle; return to IDLE.
- `start` while not IDLE is ignored (not queued).
- `data_in` is only sampled in the accept cycle; later changes have no effect.
- A zero value never yields `sign`=1.
- Hundreds nibble bits [11:10] are discarded; the overflow flag covers that range.

## Timing
- Reset values (async, immediate): `BCD_digit`=0, `sign`=0, `overflow`=0, `done`=0, `busy`=0, state IDLE, internal registers 0.
- Accept edge E0: `start`=1 in IDLE. `busy`=1 after E0.
- Shifts occur at edges E1..E_DATA_W.
- At edge E_(DATA_W+1): outputs update, `done`=1 for that cycle, and `busy` is still 1 in the DONE cycle.
- At edge E_(DATA_W+2): `done`=0, `busy`=0, IDLE.
- Back-to-back throughput is one conversion per DATA_W+2 cycles.
- Outputs change only at the DONE edge or on reset.
- Reset mid-conversion aborts: all outputs return to reset values and no `done` is generated. The next `start` after reset release converts normally.

## Configuration
- `BCD_SIGNED_EN` defined:
  - `data_in` is two's complement; magnitude from a conditional negate.
  - `sign` reflects the input MSB.
- Not defined:
  - `data_in` is unsigned, the negate logic is absent, and `sign` is constant 0.
  - `overflow` = (data_in > 399), e.g. 1023 → overflow.

## Structure
- Package `bcd_pkg`:
  - `MAX_DISPLAY` = 399, `BCD_OUT_W` = 10, `BCD_ACC_W` = 12.
  - `typedef enum` for IDLE/SHIFT/DONE.
- Sub-module `dd_add3`: combinational 4-bit "if ≥5 add 3" corrector. Instantiated three times on the accumulator nibbles.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- Signed, DATA_W=10, `data_in`=255, `start` 1 cycle → `done` at E11, `BCD_digit`=10'h255, `sign`=0, `overflow`=0, `busy` high E0..E11.
- `data_in`=-123 (10'h385) → `BCD_digit`=10'h123, `sign`=1, `overflow`=0.
- `data_in`=399 → `BCD_digit`=10'b11_1001_1001, `overflow`=0.
  - Then 400 → `BCD_digit`=0, `overflow`=1.
  - Then -512 → `BCD_digit`=0, `sign`=1, `overflow`=1.
- `data_in`=0 → `BCD_digit`=0, `sign`=0; -1 → `BCD_digit`=10'h001, `sign`=1.
- Convert 42, then pulse `start` with 77 at E3 (busy) → ignored.
  - Result: 10'h042 with exactly one `done`, and outputs held until a later accepted start.
- Assert `rst_n`=0 at E5 of a conversion of 300 → outputs 0 immediately and no `done`.
  - After release, converting 7 yields 10'h007 at E11.
  - Unsigned build: 1023 → `overflow`=1, `sign`=0.
